// File: rtl/freq_detector.sv
// freq_detector: measures the period of an externally generated divided clock
// (remote bclk/lrclk) in local clk cycles and reports the recovered divide
// factor once the period has been stable for LOCK_COUNT consecutive periods.
// Flags period changes (period_err) and loss of clock (lost).
// Optional build macro FREQ_DETECTOR_DUTY_CHECK_EN adds a 50% duty-cycle check
// on every measured period.
module freq_detector #(
    parameter  int MAX_FACTOR = 16,
    parameter  int LOCK_COUNT = 4,
    localparam int WIDTH      = $clog2(MAX_FACTOR + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sclk_in,
    output logic [WIDTH-1:0] factor,
    output logic             locked,
    output logic             period_err,
    output logic             lost
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_TWO  = WIDTH'(2);
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_FACTOR);
    localparam logic [WIDTH-1:0] CNT_SAT  = WIDTH'(MAX_FACTOR + 1);
    localparam logic [MW-1:0]    MATCH_LK = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MEAS   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic             s1_r, s2_r, s3_r;
    logic             rise_s;
    logic             meas_ok_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] cand_r, cand_s;
    logic [WIDTH-1:0] factor_r, factor_s;
    logic [MW-1:0]    match_r, match_s;
    logic             locked_r, locked_s;
    logic             err_r, err_s;
    logic             lost_r, lost_s;

    // Period range check: a measurement counts only within 2..MAX_FACTOR.
    function automatic logic period_in_range(input logic [WIDTH-1:0] p);
        return (p >= CNT_TWO) && (p <= CNT_MAX);
    endfunction

    assign rise_s = s2_r & ~s3_r;

    // Two-flop synchronizer plus delay flop for edge detection; runs regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sclk_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

`ifdef FREQ_DETECTOR_DUTY_CHECK_EN
    logic             fall_s;
    logic [WIDTH-1:0] high_cnt_r;
    logic             fall_seen_r;

    assign fall_s = ~s2_r & s3_r;

    // Capture the high-phase length at each falling edge; remember whether a fall occurred since the last rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt_r  <= '0;
            fall_seen_r <= 1'b0;
        end else if (fall_s) begin
            high_cnt_r  <= cnt_r;
            fall_seen_r <= 1'b1;
        end else if (rise_s) begin
            fall_seen_r <= 1'b0;
        end else begin
            fall_seen_r <= fall_seen_r;
        end
    end

    // Valid only with in-range period, an observed fall, and exactly half the period spent high.
    always_comb begin
        meas_ok_s = period_in_range(cnt_r) && fall_seen_r &&
                    ({high_cnt_r, 1'b0} == {1'b0, cnt_r});
    end
`else
    // Valid when the period alone is in range; odd periods are accepted.
    always_comb begin
        meas_ok_s = period_in_range(cnt_r);
    end
`endif

    // Next-state, counter, match tracking and output pulse generation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cand_s   = cand_r;
        match_s  = match_r;
        factor_s = factor_r;
        locked_s = locked_r;
        err_s    = 1'b0;
        lost_s   = 1'b0;

        if (!enable) begin
            state_s  = IDLE;
            locked_s = 1'b0;
            cnt_s    = '0;
            match_s  = '0;
        end else begin
            if (rise_s) begin
                cnt_s = CNT_ONE;
            end else if (cnt_r != CNT_SAT) begin
                cnt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end

            case (state_r)
                IDLE: begin
                    // First edge only starts the period count; nothing is measured.
                    if (rise_s) begin
                        match_s = '0;
                        state_s = MEAS;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEAS: begin
                    if (rise_s) begin
                        if (!meas_ok_s) begin
                            err_s   = 1'b1;
                            match_s = '0;
                        end else if (cnt_r == cand_r) begin
                            match_s = match_r + MW'(1);
                        end else begin
                            cand_s  = cnt_r;
                            match_s = MW'(1);
                        end
                        if (match_s == MATCH_LK) begin
                            factor_s = cand_s;
                            locked_s = 1'b1;
                            state_s  = LOCKED;
                        end else begin
                            state_s  = MEAS;
                        end
                    end else if (cnt_r == CNT_SAT) begin
                        lost_s   = 1'b1;
                        locked_s = 1'b0;
                        state_s  = IDLE;
                    end else begin
                        state_s  = MEAS;
                    end
                end
                LOCKED: begin
                    if (rise_s) begin
                        if (!meas_ok_s || (cnt_r != factor_r)) begin
                            err_s    = 1'b1;
                            locked_s = 1'b0;
                            cand_s   = meas_ok_s ? cnt_r : cand_r;
                            match_s  = meas_ok_s ? MW'(1) : MW'(0);
                            state_s  = MEAS;
                        end else begin
                            state_s  = LOCKED;
                        end
                    end else if (cnt_r == CNT_SAT) begin
                        lost_s   = 1'b1;
                        locked_s = 1'b0;
                        state_s  = IDLE;
                    end else begin
                        state_s  = LOCKED;
                    end
                end
                default: begin
                    locked_s = 1'b0;
                    state_s  = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            cand_r   <= '0;
            match_r  <= '0;
            factor_r <= '0;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
            lost_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            cand_r   <= cand_s;
            match_r  <= match_s;
            factor_r <= factor_s;
            locked_r <= locked_s;
            err_r    <= err_s;
            lost_r   <= lost_s;
        end
    end

    assign factor     = factor_r;
    assign locked     = locked_r;
    assign period_err = err_r;
    assign lost       = lost_r;

endmodule

// File: doc/freq_detector.md
Name: freq_detector

Overview:
- Receive-side counterpart of the I2S clock divider.
- Samples an externally generated divided clock (remote bclk or lrclk) in the local clk domain and measures its period in clk cycles.
- Reports the recovered divide factor once the period has been stable for a programmable number of cycles.
- Flags period changes and loss of clock.
- Used by I2S slave logic to confirm the remote master's bclk/lrclk ratio before enabling data capture.

Parameters:
- MAX_FACTOR, 16: largest period (in clk cycles) accepted as valid; must be >= 4.
- LOCK_COUNT, 4: consecutive identical valid periods required to assert locked; must be >= 1.
- WIDTH (localparam), $clog2(MAX_FACTOR+2): counter width; must represent MAX_FACTOR+1.

Ports:
- clk  input  1  local sampling clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  detector run enable
- sclk_in  input  1  clock to be measured; asynchronous to clk
- factor  output  WIDTH  last locked period in clk cycles
- locked  output  1  period stable and valid
- period_err  output  1  one-cycle pulse: measured period differs from the locked value, or is invalid
- lost  output  1  one-cycle pulse: no rising edge within MAX_FACTOR+1 cycles

Behaviour:
- Interface (already decided): reset rst, synchronous, active-high; clock clk.
- Input path:
  - sclk_in passes through a 2-FF synchronizer (s1, s2), then a delay flop s3.
  - Rising edge detect is rise = s2 & ~s3. Edge-detect latency from sclk_in is 2-3 clk cycles.
  - The synchronizer runs regardless of enable; rst clears s1..s3 to 0.
- Counter cnt (WIDTH bits):
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at MAX_FACTOR+1.
  - The measured period is the value of cnt in the cycle rise is high. Example: a factor-4 square wave gives measured = 4.
- Valid measurement: 2 <= measured <= MAX_FACTOR.
- States:
  - IDLE: waiting for the first rise after reset or enable. On rise, clear match count and go to MEAS. No measurement is taken on this edge.
  - MEAS: on each rise, take a measurement.
    - Invalid measurement: period_err pulse, match <= 0.
    - Valid and equal to cand: match <= match+1.
    - Otherwise: cand <= measured, match <= 1.
    - When the update makes match reach LOCK_COUNT: factor <= cand, locked <= 1, go to LOCKED.
  - LOCKED: on each rise, if measured != factor, pulse period_err, drop locked, cand <= measured (if valid), match <= 1 (0 if invalid), go to MEAS.
- Timeout: in MEAS or LOCKED, if cnt reaches MAX_FACTOR+1 with no rise, pulse lost for one cycle, drop locked, and go to IDLE. lost pulses once per timeout, not every cycle of saturation.
- Simultaneous events: rise takes priority over timeout in the same cycle. An invalid measurement handled by rise produces period_err, not lost.
- enable low: state <= IDLE, locked <= 0, cnt <= 0, match <= 0. factor holds its last value. No pulses are issued.
- Reset values: factor 0, locked 0, period_err 0, lost 0, state IDLE, cnt 0, match 0, cand 0.
- Reset mid-operation: all of the above is applied in the next cycle. Lock must be re-acquired from IDLE.
- Latency: locked rises in the cycle after the (LOCK_COUNT+1)-th detected rising edge following enable. With LOCK_COUNT=4 and factor 8, that is about 5 periods plus 3 cycles.
- Width rules: match is $clog2(LOCK_COUNT+1) bits. All comparisons are unsigned at WIDTH bits.

Optional Feature:
- Macro: FREQ_DETECTOR_DUTY_CHECK_EN.
- Defined:
  - Falling edge detect fall = ~s2 & s3.
  - A register high_cnt captures cnt at fall.
  - At each measuring rise, the measurement is valid only if it also satisfies 2*high_cnt == measured (50% duty, even period).
  - A duty failure is treated as an invalid measurement: period_err pulse, match <= 0, lock lost if in LOCKED.
  - If no fall occurred since the previous rise, the measurement is invalid.
- Not defined: fall logic and high_cnt are absent. Only the period is checked; odd periods in 2..MAX_FACTOR are valid.

Test Plan:
- Lock acquisition: rst 2 cycles, enable=1, sclk_in square wave of period 8 clk → locked=1 with factor=8 after the 5th rise. period_err and lost stay 0 throughout.
- Period change: while locked at 8, switch sclk_in to period 6 → period_err pulses exactly once, locked=0, then relocks with factor=6 after 4 more edges.
- Clock loss: while locked, hold sclk_in low → lost pulses once, 17 cycles after the last rise (MAX_FACTOR=16); locked=0, state IDLE. factor stays 8.
- Out of range: period 20 with MAX_FACTOR=16 → lost pulses each period, never locks. Period 2 locks with factor=2.
- Enable/reset mid-operation: drop enable for 1 cycle while locked → locked=0 next cycle and factor holds. Assert rst → factor=0, and relock needs the full LOCK_COUNT+1 edges.
- Duty check (macro defined): period 8 with high 3/low 5 → period_err on every rise, never locks. With the macro undefined, the same stimulus locks at factor=8.
